// File: rtl/mem_bank_stack.sv
// mem_bank_stack: active memory-bank register with a LIFO save/restore stack.
//
// Holds the bank number that drives the address decoder. A push saves the
// current bank and switches to new_bank; a pop restores the most recently
// saved bank; push+pop together replace the bank without changing depth.
// Rejected pushes (full) and pops/replaces (empty) raise sticky flags.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   set_en          load new_bank, stack untouched
//   push_en/pop_en  push, pop, or replace when both are high
//   new_bank        value for set/push/replace
//   err_clr         clear sticky ovf/unf (a same-cycle error wins)
//   bank            active bank
//   top             top stack entry, 0 when empty
//   level           saved-entry count 0..DEPTH
//   empty, full     decoded from level
//   ovf, unf        sticky overflow / underflow
module mem_bank_stack #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned LW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic             push_en,
  input  logic             pop_en,
  input  logic [WIDTH-1:0] new_bank,
  input  logic             err_clr,
  output logic [WIDTH-1:0] bank,
  output logic [WIDTH-1:0] top,
  output logic [LW-1:0]    level,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  logic [WIDTH-1:0] bank_q, bank_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             empty_w, full_w;
  logic [WIDTH-1:0] top_w;
  logic             ovf_evt, unf_evt;

  assign empty_w = (level_q == '0);
  assign full_w  = (level_q == LW'(DEPTH));

  // Top of stack is the entry just below level; loop compare avoids an index
  // wider than the array needs.
  always_comb begin
    top_w = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (LW'(i + 1) == level_q) top_w = stack_q[i];
    end
  end

  always_comb begin
    bank_d  = bank_q;
    level_d = level_q;
    stack_d = stack_q;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;

    if (push_en && pop_en) begin
      // Replace: net pop+push, popped value discarded, old bank not saved.
      if (empty_w) unf_evt = 1'b1;
      else         bank_d  = new_bank;
    end else if (pop_en) begin
      if (empty_w) begin
        unf_evt = 1'b1;
      end else begin
        bank_d  = top_w;
        level_d = level_q - LW'(1);
      end
    end else if (push_en) begin
      if (full_w) begin
        ovf_evt = 1'b1;
      end else begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (LW'(i) == level_q) stack_d[i] = bank_q;
        end
        level_d = level_q + LW'(1);
        bank_d  = new_bank;
      end
    end else if (set_en) begin
      bank_d = new_bank;
    end

    ovf_d = (ovf_q & ~err_clr) | ovf_evt;
    unf_d = (unf_q & ~err_clr) | unf_evt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      bank_q  <= bank_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      stack_q <= stack_d;
    end
  end

  assign bank  = bank_q;
  assign top   = top_w;
  assign level = level_q;
  assign empty = empty_w;
  assign full  = full_w;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_mem_bank_stack.sv
// tb_mem_bank_stack: directed + randomized bench for mem_bank_stack against a
// queue-based reference model of the bank stack.
module tb_mem_bank_stack;

  localparam int unsigned WIDTH = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             set_en, push_en, pop_en, err_clr;
  logic [WIDTH-1:0] new_bank;
  logic [WIDTH-1:0] bank, top;
  logic [LW-1:0]    level;
  logic             empty, full, ovf, unf;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model
  logic [WIDTH-1:0] m_bank;
  logic [WIDTH-1:0] m_stack [$];
  logic             m_ovf, m_unf;

  always #5 clk = ~clk;

  mem_bank_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .set_en   (set_en),
    .push_en  (push_en),
    .pop_en   (pop_en),
    .new_bank (new_bank),
    .err_clr  (err_clr),
    .bank     (bank),
    .top      (top),
    .level    (level),
    .empty    (empty),
    .full     (full),
    .ovf      (ovf),
    .unf      (unf)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bank = '0;
    m_stack.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic pu, input logic po,
                            input logic [WIDTH-1:0] nb, input logic clr);
    logic eo, eu;
    eo = 1'b0;
    eu = 1'b0;
    if (pu && po) begin
      if (m_stack.size() == 0) eu = 1'b1;
      else                     m_bank = nb;
    end else if (po) begin
      if (m_stack.size() == 0) eu = 1'b1;
      else                     m_bank = m_stack.pop_back();
    end else if (pu) begin
      if (m_stack.size() == DEPTH) eo = 1'b1;
      else begin
        m_stack.push_back(m_bank);
        m_bank = nb;
      end
    end else if (s) begin
      m_bank = nb;
    end
    m_ovf = (m_ovf && !clr) || eo;
    m_unf = (m_unf && !clr) || eu;
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = m_stack.size();
    check_eq({tag, ".bank"},  32'(bank),  32'(m_bank));
    check_eq({tag, ".level"}, 32'(level), 32'(sz));
    check_eq({tag, ".top"},   32'(top),   (sz > 0) ? 32'(m_stack[sz-1]) : 32'd0);
    check_eq({tag, ".empty"}, 32'(empty), 32'(sz == 0));
    check_eq({tag, ".full"},  32'(full),  32'(sz == DEPTH));
    check_eq({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
    check_eq({tag, ".unf"},   32'(unf),   32'(m_unf));
  endtask

  // Drive one command, clock it, sample 1 time unit after the edge.
  task automatic cmd(input string tag, input logic s, input logic pu, input logic po,
                     input logic [WIDTH-1:0] nb, input logic clr);
    set_en   = s;
    push_en  = pu;
    pop_en   = po;
    new_bank = nb;
    err_clr  = clr;
    @(posedge clk);
    #1;
    model_step(s, pu, po, nb, clr);
    check_all(tag);
  endtask

  // Assert reset between edges and check outputs before the next edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    set_en   = 1'b0;
    push_en  = 1'b0;
    pop_en   = 1'b0;
    err_clr  = 1'b0;
    new_bank = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // SET / hold / set+push
    cmd("set2", 1, 0, 0, 2'd2, 0);
    check_eq("set2.bank_const", 32'(bank), 32'd2);
    cmd("idle0", 0, 0, 0, 2'd1, 0);
    cmd("idle1", 0, 0, 0, 2'd3, 0);
    cmd("setpush", 1, 1, 0, 2'd1, 0);
    check_eq("setpush.level_const", 32'(level), 32'd1);

    // Push to full and overflow from bank 0
    async_reset("rst_mid");
    cmd("push1", 0, 1, 0, 2'd1, 0);
    cmd("push2", 0, 1, 0, 2'd2, 0);
    cmd("push3", 0, 1, 0, 2'd3, 0);
    cmd("push4", 0, 1, 0, 2'd1, 0);
    check_eq("full.top_const", 32'(top), 32'd3);
    cmd("push_ovf", 0, 1, 0, 2'd2, 0);
    check_eq("ovf.bank_const", 32'(bank), 32'd1);
    check_eq("ovf.flag_const", 32'(ovf), 32'd1);
    cmd("replace_full", 0, 1, 1, 2'd0, 0);

    // Error clear priority
    cmd("clr_vs_ovf", 0, 1, 0, 2'd3, 1);
    check_eq("clr_vs_ovf.const", 32'(ovf), 32'd1);
    cmd("clr_alone", 0, 0, 0, 2'd0, 1);
    check_eq("clr_alone.const", 32'(ovf), 32'd0);

    // Pop to empty and underflow
    for (int i = 0; i < 4; i++) cmd("pop", 0, 0, 1, 2'd0, 0);
    check_eq("popped.empty_const", 32'(empty), 32'd1);
    cmd("pop_unf", 0, 0, 1, 2'd2, 0);
    check_eq("pop_unf.const", 32'(unf), 32'd1);
    cmd("clr_unf", 0, 0, 0, 2'd0, 1);
    cmd("replace_empty", 0, 1, 1, 2'd3, 0);
    check_eq("replace_empty.bank_const", 32'(bank), 32'd0);

    // Replace with depth 2
    cmd("r_set", 1, 0, 0, 2'd2, 1);
    cmd("r_push", 0, 1, 0, 2'd1, 0);
    cmd("r_push2", 0, 1, 0, 2'd2, 0);
    cmd("r_pop", 0, 0, 1, 2'd0, 0);
    cmd("replace", 0, 1, 1, 2'd3, 0);

    // Randomized traffic with phase-varying push/pop bias
    for (int i = 0; i < 1500; i++) begin
      int r, bias;
      logic s, pu, po, clr;
      bias = ((i / 100) % 2 == 0) ? 65 : 35;
      r    = $urandom_range(0, 99);
      pu   = (r < bias);
      po   = ($urandom_range(0, 99) < (100 - bias));
      s    = ($urandom_range(0, 3) == 0);
      clr  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 199) == 0) async_reset("rnd_rst");
      cmd("rnd", s, pu, po, WIDTH'($urandom), clr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
